mux_sel_arbiter: RTL

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

---
 rtl/mux_sel_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin select generator for a downstream 4:1 mux.
// Offers one channel at a time (sel/valid/gnt, all registered) and holds the
// offer until ready accepts it. Optional burst mode is controlled by the
// macro MUX_SEL_ARBITER_BURST_EN: when defined, a channel may keep the grant
// for up to MAX_HOLD consecutive transfers; when undefined, the grant
// rotates after every accepted transfer and MAX_HOLD has no effect.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ready,
  output logic [1:0] sel,
  output logic       valid,
  output logic [3:0] gnt
);

  // Reject out-of-range hold limits at elaboration time.
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_range
    $error("mux_sel_arbiter: MAX_HOLD must be within 1..15");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_r;
  logic [1:0] last_r;        // channel that completed the most recent burst
  logic [1:0] pick_idle_s;   // round-robin winner starting after last_r
  logic [1:0] pick_next_s;   // round-robin winner starting after sel
  logic       any_req_s;
  logic       stay_s;        // accepted transfer keeps the same channel

`ifdef MUX_SEL_ARBITER_BURST_EN
  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);
  logic [3:0] beat_r;        // transfers completed in the current burst
`endif

  // First requester scanning base+1, base+2, base+3, base; base itself is
  // reached last, so the current channel only wins when nobody else asks.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = base;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = base + 2'(k);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // One-hot decode of a channel number.
  function automatic logic [3:0] onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  // Arbitration decisions derived from the current request vector.
  always_comb begin
    any_req_s   = |req;
    pick_idle_s = rr_pick(req, last_r);
    pick_next_s = rr_pick(req, sel);
`ifdef MUX_SEL_ARBITER_BURST_EN
    if (req[sel] && ((beat_r + 4'd1) < HOLD_LIM)) begin
      stay_s = 1'b1;
    end else begin
      stay_s = 1'b0;
    end
`else
    stay_s = 1'b0;
`endif
  end

  // Arbiter FSM with registered sel/valid/gnt outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      valid   <= 1'b0;
      sel     <= 2'd0;
      gnt     <= 4'b0000;
      last_r  <= 2'd3;
`ifdef MUX_SEL_ARBITER_BURST_EN
      beat_r  <= 4'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r <= GRANT;
            valid   <= 1'b1;
            sel     <= pick_idle_s;
            gnt     <= onehot(pick_idle_s);
`ifdef MUX_SEL_ARBITER_BURST_EN
            beat_r  <= 4'd0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (ready) begin
            if (stay_s) begin
`ifdef MUX_SEL_ARBITER_BURST_EN
              beat_r <= beat_r + 4'd1;
`endif
            end else begin
              last_r <= sel;
`ifdef MUX_SEL_ARBITER_BURST_EN
              beat_r <= 4'd0;
`endif
              if (any_req_s) begin
                sel <= pick_next_s;
                gnt <= onehot(pick_next_s);
              end else begin
                state_r <= IDLE;
                valid   <= 1'b0;
                gnt     <= 4'b0000;
              end
            end
          end else begin
            // Offer is held unchanged until accepted.
            state_r <= GRANT;
          end
        end
        default: begin
          state_r <= IDLE;
          valid   <= 1'b0;
          gnt     <= 4'b0000;
        end
      endcase
    end
  end

endmodule
